// File: rtl/btn_cond_if.sv
// Button conditioner bus: raw button inputs plus all per-channel conditioned outputs.
// Latency: none, this is wiring only.
// Backpressure: none; every signal is a free-running level or a one-cycle pulse.
//
// Ports (all N bits wide, one bit per channel):
//   btn_i        raw asynchronous button inputs, active-high
//   level_o      debounced button state
//   press_o      one-cycle pulse on an accepted rising level
//   release_o    one-cycle pulse on an accepted falling level
//   long_press_o one-cycle pulse when the hold reaches the long-press time
//   repeat_o     one-cycle auto-repeat pulses while held
interface btn_cond_if #(
  parameter int N = 4
);
  logic [N-1:0] btn_i;
  logic [N-1:0] level_o;
  logic [N-1:0] press_o;
  logic [N-1:0] release_o;
  logic [N-1:0] long_press_o;
  logic [N-1:0] repeat_o;

  // master: the side that presses buttons and watches the events
  modport master (
    output btn_i,
    input  level_o, press_o, release_o, long_press_o, repeat_o
  );

  // slave: the conditioner itself
  modport slave (
    input  btn_i,
    output level_o, press_o, release_o, long_press_o, repeat_o
  );
endinterface

// File: rtl/btn_cond.sv
// Per-channel button conditioner: 2-flop sync, debounce, press/release/long-press/auto-repeat events.
// Latency: clean btn_i edge to level_o change is 2+DB_CYCLES cycles; event pulses coincide with level.
// Backpressure: none; outputs are free-running levels and one-cycle pulses that cannot be stalled.
//
// Ports:
//   mclk   sole clock, rising edge
//   rst_n  asynchronous active-low reset; clears every flop and forces all FSMs to IDLE
//   bus    btn_cond_if slave modport: btn_i in; level_o, press_o, release_o,
//          long_press_o, repeat_o out (N bits each, one bit per channel)
module btn_cond #(
  parameter int N             = 4,
  parameter int DB_CYCLES     = 4,
  parameter int LONG_CYCLES   = 20,
  parameter int REPEAT_CYCLES = 8,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic       mclk,
  input  logic       rst_n,
  btn_cond_if.slave  bus
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int LW  = $clog2(LONG_CYCLES + 1);
  localparam int RW  = $clog2(REPEAT_CYCLES + 1);
  // One hold counter serves both HELD (counts to LONG_CYCLES-1) and REPEAT
  // (counts to REPEAT_CYCLES-1), so it is sized for the larger of the two.
  localparam int CW  = (LW > RW) ? LW : RW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_REPEAT
  } state_e;

  logic [N-1:0] level_v;
  logic [N-1:0] press_v;
  logic [N-1:0] release_v;
  logic [N-1:0] long_v;
  logic [N-1:0] repeat_v;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic           sync1_q, sync2_q;
    logic           level_q, level_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    state_e         state_q, state_d;
    logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
    logic           press_q, press_d;
    logic           rel_q, rel_d;
    logic           long_q, long_d;
    logic           rpt_q, rpt_d;
    logic           rise, fall;

    always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        level_q    <= 1'b0;
        db_cnt_q   <= '0;
        state_q    <= ST_IDLE;
        hold_cnt_q <= '0;
        press_q    <= 1'b0;
        rel_q      <= 1'b0;
        long_q     <= 1'b0;
        rpt_q      <= 1'b0;
      end else begin
        sync1_q    <= bus.btn_i[i];
        sync2_q    <= sync1_q;
        level_q    <= level_d;
        db_cnt_q   <= db_cnt_d;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        press_q    <= press_d;
        rel_q      <= rel_d;
        long_q     <= long_d;
        rpt_q      <= rpt_d;
      end
    end

    // Debounce: the counter only survives across consecutive differing
    // samples; any sample matching level wipes it, so short glitches never
    // accumulate.
    always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (sync2_q != level_q) begin
        if (db_cnt_q == DBW'(DB_CYCLES - 1)) begin
          level_d = sync2_q;
        end else begin
          db_cnt_d = db_cnt_q + DBW'(1);
        end
      end
    end

    // Edges are taken from level_d so the registered pulses line up with the
    // first cycle level_q shows the new value.
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // Hold FSM. A fall is checked first in HELD/REPEAT so a release landing on
    // a long-press or repeat cycle suppresses those pulses.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = rise;
      rel_d      = fall;
      long_d     = 1'b0;
      rpt_d      = 1'b0;
      case (state_q)
        ST_IDLE: begin
          hold_cnt_d = '0;
          if (rise) begin
            state_d = ST_HELD;
          end
        end
        ST_HELD: begin
          if (fall) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
          end else if (hold_cnt_q == CW'(LONG_CYCLES - 1)) begin
            state_d    = ST_REPEAT;
            hold_cnt_d = '0;
            long_d     = 1'b1;
            rpt_d      = REPEAT_EN;
          end else begin
            hold_cnt_d = hold_cnt_q + CW'(1);
          end
        end
        ST_REPEAT: begin
          if (fall) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
          end else if (hold_cnt_q == CW'(REPEAT_CYCLES - 1)) begin
            hold_cnt_d = '0;
            rpt_d      = REPEAT_EN;
          end else begin
            hold_cnt_d = hold_cnt_q + CW'(1);
          end
        end
        default: begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end

    assign level_v[i]   = level_q;
    assign press_v[i]   = press_q;
    assign release_v[i] = rel_q;
    assign long_v[i]    = long_q;
    assign repeat_v[i]  = rpt_q;
  end

  assign bus.level_o      = level_v;
  assign bus.press_o      = press_v;
  assign bus.release_o    = release_v;
  assign bus.long_press_o = long_v;
  assign bus.repeat_o     = repeat_v;

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond: reset, debounce, long press, auto-repeat, release priority.
// Cycle c of each scenario is the interval after the c-th rising edge; inputs change at
// edge+1, outputs are compared at the falling edge of the same cycle.
module tb_btn_cond;
  localparam int N = 4;

  logic mclk = 1'b0;
  logic rst_n;
  int   vec  = 0;
  int   errs = 0;

  logic [5*N-1:0] obs;
  logic [5*N-1:0] exp_v;
  logic [N-1:0]   e_lvl, e_prs, e_rel, e_lp, e_rp;

  btn_cond_if #(.N(N)) bus ();
  btn_cond_if #(.N(N)) bus_nr ();

  btn_cond #(
    .N(N), .DB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(1'b1)
  ) u_dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  btn_cond #(
    .N(N), .DB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(1'b0)
  ) u_norep (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus_nr)
  );

  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.btn_i    = '0;
    bus_nr.btn_i = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.btn_i    = '1;
    bus_nr.btn_i = '1;
    #1;
    obs = {bus.level_o, bus.press_o, bus.release_o, bus.long_press_o, bus.repeat_o};
    vec++;
    if (obs !== '0) begin
      errs++;
      $display("FAIL reset_async: got %h expected %h", obs, {5*N{1'b0}});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge mclk);
      obs = {bus.level_o, bus.press_o, bus.release_o, bus.long_press_o, bus.repeat_o};
      vec++;
      if (obs !== '0) begin
        errs++;
        $display("FAIL reset_held c=%0d: got %h expected %h", c, obs, {5*N{1'b0}});
      end
    end
    step();
    rst_n = 1'b1;
    // Buttons held through reset: nothing in the first cycles, then a fresh press on all.
    for (int c = 0; c <= 8; c++) begin
      @(negedge mclk);
      e_lvl = (c >= 6) ? '1 : '0;
      e_prs = (c == 6) ? '1 : '0;
      exp_v = {e_lvl, e_prs, {3*N{1'b0}}};
      obs = {bus.level_o, bus.press_o, bus.release_o, bus.long_press_o, bus.repeat_o};
      vec++;
      if (obs !== exp_v) begin
        errs++;
        $display("FAIL reset_release c=%0d: got %h expected %h", c, obs, exp_v);
      end
      obs = {bus_nr.level_o, bus_nr.press_o, bus_nr.release_o, bus_nr.long_press_o, bus_nr.repeat_o};
      vec++;
      if (obs !== exp_v) begin
        errs++;
        $display("FAIL reset_release_norep c=%0d: got %h expected %h", c, obs, exp_v);
      end
      step();
    end
    idle(14);
  endtask

  task automatic test_clean_press();
    for (int c = 0; c <= 16; c++) begin
      if (c == 0) bus.btn_i[0] = 1'b1;
      if (c == 8) bus.btn_i[0] = 1'b0;
      @(negedge mclk);
      e_lvl = (c >= 6 && c < 14) ? 4'b0001 : 4'b0000;
      e_prs = (c == 6)  ? 4'b0001 : 4'b0000;
      e_rel = (c == 14) ? 4'b0001 : 4'b0000;
      exp_v = {e_lvl, e_prs, e_rel, {2*N{1'b0}}};
      obs = {bus.level_o, bus.press_o, bus.release_o, bus.long_press_o, bus.repeat_o};
      vec++;
      if (obs !== exp_v) begin
        errs++;
        $display("FAIL clean_press c=%0d: got %h expected %h", c, obs, exp_v);
      end
      step();
    end
    idle(6);
  endtask

  task automatic test_glitch();
    for (int c = 0; c <= 14; c++) begin
      bus.btn_i[1] = (c < 3);
      @(negedge mclk);
      obs = {bus.level_o, bus.press_o, bus.release_o, bus.long_press_o, bus.repeat_o};
      vec++;
      if (obs !== '0) begin
        errs++;
        $display("FAIL glitch c=%0d: got %h expected %h", c, obs, {5*N{1'b0}});
      end
      step();
    end
    idle(4);
  endtask

  task automatic test_long_repeat();
    for (int c = 0; c <= 55; c++) begin
      if (c == 0)  bus.btn_i[2] = 1'b1;
      if (c == 40) bus.btn_i[2] = 1'b0;
      @(negedge mclk);
      e_lvl = (c >= 6 && c < 46) ? 4'b0100 : 4'b0000;
      e_prs = (c == 6)  ? 4'b0100 : 4'b0000;
      e_rel = (c == 46) ? 4'b0100 : 4'b0000;
      e_lp  = (c == 26) ? 4'b0100 : 4'b0000;
      e_rp  = (c == 26 || c == 34 || c == 42) ? 4'b0100 : 4'b0000;
      exp_v = {e_lvl, e_prs, e_rel, e_lp, e_rp};
      obs = {bus.level_o, bus.press_o, bus.release_o, bus.long_press_o, bus.repeat_o};
      vec++;
      if (obs !== exp_v) begin
        errs++;
        $display("FAIL long_repeat c=%0d: got %h expected %h", c, obs, exp_v);
      end
      step();
    end
    idle(4);
  endtask

  task automatic test_release_at_long();
    for (int c = 0; c <= 32; c++) begin
      if (c == 0)  bus.btn_i[3] = 1'b1;
      if (c == 20) bus.btn_i[3] = 1'b0;
      @(negedge mclk);
      e_lvl = (c >= 6 && c < 26) ? 4'b1000 : 4'b0000;
      e_prs = (c == 6)  ? 4'b1000 : 4'b0000;
      e_rel = (c == 26) ? 4'b1000 : 4'b0000;
      exp_v = {e_lvl, e_prs, e_rel, {2*N{1'b0}}};
      obs = {bus.level_o, bus.press_o, bus.release_o, bus.long_press_o, bus.repeat_o};
      vec++;
      if (obs !== exp_v) begin
        errs++;
        $display("FAIL release_at_long c=%0d: got %h expected %h", c, obs, exp_v);
      end
      step();
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    // Second press must time its long press from its own rise, not the first.
    for (int c = 0; c <= 80; c++) begin
      if (c == 0)  bus.btn_i[2] = 1'b1;
      if (c == 30) bus.btn_i[2] = 1'b0;
      if (c == 40) bus.btn_i[2] = 1'b1;
      if (c == 70) bus.btn_i[2] = 1'b0;
      @(negedge mclk);
      e_lvl = ((c >= 6 && c < 36) || (c >= 46 && c < 76)) ? 4'b0100 : 4'b0000;
      e_prs = (c == 6  || c == 46) ? 4'b0100 : 4'b0000;
      e_rel = (c == 36 || c == 76) ? 4'b0100 : 4'b0000;
      e_lp  = (c == 26 || c == 66) ? 4'b0100 : 4'b0000;
      e_rp  = (c == 26 || c == 34 || c == 66 || c == 74) ? 4'b0100 : 4'b0000;
      exp_v = {e_lvl, e_prs, e_rel, e_lp, e_rp};
      obs = {bus.level_o, bus.press_o, bus.release_o, bus.long_press_o, bus.repeat_o};
      vec++;
      if (obs !== exp_v) begin
        errs++;
        $display("FAIL back_to_back c=%0d: got %h expected %h", c, obs, exp_v);
      end
      step();
    end
    idle(4);
  endtask

  task automatic test_reset_mid_hold();
    for (int c = 0; c <= 40; c++) begin
      if (c == 0)  bus.btn_i[0] = 1'b1;
      if (c == 16) rst_n = 1'b0;
      if (c == 19) rst_n = 1'b1;
      if (c == 30) bus.btn_i[0] = 1'b0;
      @(negedge mclk);
      e_lvl = ((c >= 6 && c < 16) || (c >= 25 && c < 36)) ? 4'b0001 : 4'b0000;
      e_prs = (c == 6 || c == 25) ? 4'b0001 : 4'b0000;
      e_rel = (c == 36) ? 4'b0001 : 4'b0000;
      exp_v = {e_lvl, e_prs, e_rel, {2*N{1'b0}}};
      obs = {bus.level_o, bus.press_o, bus.release_o, bus.long_press_o, bus.repeat_o};
      vec++;
      if (obs !== exp_v) begin
        errs++;
        $display("FAIL reset_mid_hold c=%0d: got %h expected %h", c, obs, exp_v);
      end
      step();
    end
    idle(4);
  endtask

  task automatic test_no_repeat();
    for (int c = 0; c <= 66; c++) begin
      if (c == 0)  bus_nr.btn_i[0] = 1'b1;
      if (c == 56) bus_nr.btn_i[0] = 1'b0;
      @(negedge mclk);
      e_lvl = (c >= 6 && c < 62) ? 4'b0001 : 4'b0000;
      e_prs = (c == 6)  ? 4'b0001 : 4'b0000;
      e_rel = (c == 62) ? 4'b0001 : 4'b0000;
      e_lp  = (c == 26) ? 4'b0001 : 4'b0000;
      exp_v = {e_lvl, e_prs, e_rel, e_lp, {N{1'b0}}};
      obs = {bus_nr.level_o, bus_nr.press_o, bus_nr.release_o, bus_nr.long_press_o, bus_nr.repeat_o};
      vec++;
      if (obs !== exp_v) begin
        errs++;
        $display("FAIL no_repeat c=%0d: got %h expected %h", c, obs, exp_v);
      end
      step();
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_repeat();
    test_release_at_long();
    test_back_to_back();
    test_reset_mid_hold();
    test_no_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
